// File: rtl/qsys_system_onchip_mem_reader.sv
// qsys_system_onchip_mem_reader
//   Burst reader for a single-cycle-latency on-chip memory. A start pulse in
//   IDLE latches a base word address and a length (clamped to 1024 words).
//   Reads are issued while the output FIFO has room for the returning data.
//   The data is streamed out with sop/eop framing.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   start               : one-cycle launch pulse, honoured only when idle
//   base_address        : first word address (10 bits), sampled with start
//   length              : burst length in words (11 bits), sampled with start
//   busy, done          : burst in progress / one-cycle completion pulse
//   address, byteenable,
//   chipselect, write,
//   writedata, clken    : memory master port (read-only use)
//   readdata            : memory data, valid one cycle after chipselect
//   out_data, out_valid,
//   out_ready, out_sop,
//   out_eop             : output stream
module qsys_system_onchip_mem_reader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  base_address,
  input  logic [10:0] length,
  output logic        busy,
  output logic        done,
  output logic [9:0]  address,
  output logic [3:0]  byteenable,
  output logic        chipselect,
  output logic        write,
  output logic [31:0] writedata,
  output logic        clken,
  input  logic [31:0] readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0] DEPTH_C = (AW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [9:0]  next_addr;
  logic [9:0]  addr_hold;
  logic [10:0] issue_left;
  logic [10:0] len_eff;
  logic        first_pend;
  logic        zero_done;
  logic        issue;
  logic        room;

  logic        vld_p1;
  logic        sop_p1;
  logic        eop_p1;

  logic [33:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count;
  logic [33:0]   head;
  logic          push, pop, eop_hs;

  assign byteenable = 4'b1111;
  assign write      = 1'b0;
  assign writedata  = '0;
  assign clken      = 1'b1;

  assign len_eff = (length > 11'd1024) ? 11'd1024 : length;

  // A slot counts as taken once its read is in flight, so the FIFO cannot overflow.
  assign room  = ({1'b0, fifo_count} + {{(AW+1){1'b0}}, vld_p1}) < DEPTH_C;
  assign issue = (state == RUN) && (issue_left != 11'd0) && room;

  assign chipselect = issue;
  assign address    = issue ? next_addr : addr_hold;

  assign head      = fifo_mem[rd_ptr];
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? head[31:0] : '0;
  assign out_sop   = out_valid & head[33];
  assign out_eop   = out_valid & head[32];

  assign push   = vld_p1;
  assign pop    = out_valid & out_ready;
  assign eop_hs = pop & head[32];

  assign busy = (state != IDLE);
  assign done = ((state == DRAIN) && eop_hs) || zero_done;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (len_eff != 11'd0)) state_nxt = RUN;
      RUN:     if (issue && (issue_left == 11'd1)) state_nxt = DRAIN;
      DRAIN:   if (eop_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: issue side -- state, address generation and burst counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      next_addr  <= '0;
      addr_hold  <= '0;
      issue_left <= '0;
      first_pend <= 1'b0;
      zero_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      zero_done <= (state == IDLE) && start && (len_eff == 11'd0);
      if ((state == IDLE) && start) begin
        next_addr  <= base_address;
        issue_left <= len_eff;
        first_pend <= 1'b1;
      end else if (issue) begin
        addr_hold  <= next_addr;
        next_addr  <= next_addr + 10'd1;
        issue_left <= issue_left - 11'd1;
        first_pend <= 1'b0;
      end
    end
  end

  // Stage p1: read data returns; framing tags travel with the read
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= issue;
  end

  always_ff @(posedge clk) begin
    sop_p1 <= first_pend;
    eop_p1 <= (issue_left == 11'd1);
  end

  // Stage p2: output FIFO
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {sop_p1, eop_p1, readdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_qsys_system_onchip_mem_reader.sv
module tb_qsys_system_onchip_mem_reader;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_address;
  logic [10:0] length;
  logic        busy, done;
  logic [9:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect, write;
  logic [31:0] writedata;
  logic        clken;
  logic [31:0] readdata = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop, out_eop;

  qsys_system_onchip_mem_reader #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_address(base_address),
    .length(length), .busy(busy), .done(done), .address(address),
    .byteenable(byteenable), .chipselect(chipselect), .write(write),
    .writedata(writedata), .clken(clken), .readdata(readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop)
  );

  always #5 clk = ~clk;

  // Memory model: word i holds i, one-cycle read latency.
  logic [31:0] mem [1024];
  always @(posedge clk) if (chipselect) readdata <= mem[address];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = -1;
  int first_cs = -1;
  int first_vld = -1;
  int done_cnt, valid_cnt, busy_cnt, issued, accepted;
  bit ovf, exp_zero, stall_prev, done_prev;
  bit rmode = 1'b0;
  logic [33:0] stall_word;
  logic [9:0]  cs_addr_q[$];
  logic [31:0] wd_q[$];
  bit          ws_q[$];
  bit          we_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Consumer ready: constant 1, or the repeating pattern 1,0,0.
  initial begin
    int rphase = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rmode) begin
        out_ready = (rphase == 0);
        rphase = (rphase + 1) % 3;
      end else begin
        out_ready = 1'b1;
        rphase = 0;
      end
    end
  end

  // Monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chipselect) begin
        cs_addr_q.push_back(address);
        issued++;
        if (first_cs < 0) first_cs = cyc;
      end
      if (issued - accepted > FIFO_DEPTH) ovf = 1'b1;
      if (stall_prev)
        check("stall_hold", {out_valid, out_sop, out_eop, out_data}, {1'b1, stall_word});
      if (out_valid) begin
        valid_cnt++;
        if (first_vld < 0) first_vld = cyc;
      end
      if (busy) busy_cnt++;
      if (done_prev) check("busy_after_done", busy, 0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_hs", out_valid & out_ready & out_eop, !exp_zero);
      end
      if (out_valid && out_ready) begin
        wd_q.push_back(out_data);
        ws_q.push_back(out_sop);
        we_q.push_back(out_eop);
        accepted++;
      end
      stall_prev = out_valid && !out_ready;
      stall_word = {out_sop, out_eop, out_data};
      done_prev  = done;
    end
  end

  task automatic start_burst(input logic [9:0] b, input logic [10:0] l, input bit clear);
    @(posedge clk); #1;
    if (clear) begin
      cs_addr_q.delete(); wd_q.delete(); ws_q.delete(); we_q.delete();
      done_cnt = 0; valid_cnt = 0; busy_cnt = 0; issued = 0; accepted = 0;
      ovf = 1'b0; first_cs = -1; first_vld = -1; done_cyc = -1;
      exp_zero = (l == 11'd0);
    end
    start = 1'b1; base_address = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
    if (clear) start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (done_cnt == 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("done_seen", done_cnt != 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_burst(input logic [9:0] b, input int n);
    logic [9:0] a;
    check("n_words", wd_q.size(), n);
    check("n_reads", cs_addr_q.size(), n);
    check("done_cnt", done_cnt, 1);
    check("outstanding_ovf", ovf, 0);
    for (int i = 0; i < n; i++) begin
      a = b + 10'(i);
      if (i < cs_addr_q.size()) check("rd_addr", cs_addr_q[i], a);
      if (i < wd_q.size()) begin
        check("data", wd_q[i], {22'b0, a});
        check("sop", ws_q[i], (i == 0));
        check("eop", we_q[i], (i == n - 1));
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cs"}, chipselect, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_sop"}, out_sop, 0);
    check({tag, "_eop"}, out_eop, 0);
    check({tag, "_addr"}, address, 0);
    check({tag, "_data"}, out_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i;
    reset = 1'b1; start = 1'b0; base_address = '0; length = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("byteenable", byteenable, 4'hF);
    check("write", write, 0);
    check("writedata", writedata, 0);
    check("clken", clken, 1);
    @(posedge clk); #1 reset = 1'b0;

    // Basic burst, full-rate consumer: latency and throughput.
    start_burst(10'h010, 11'd4, 1);
    wait_done(50);
    check_burst(10'h010, 4);
    check("first_cs_lat", first_cs - start_cyc, 1);
    check("first_vld_lat", first_vld - start_cyc, 3);
    check("valid_cycles", valid_cnt, 4);
    check("busy_cycles", busy_cnt, 6);
    check("done_cyc", done_cyc - start_cyc, 6);

    // Address wrap 1023 -> 0.
    start_burst(10'h3FE, 11'd4, 1);
    wait_done(50);
    check_burst(10'h3FE, 4);

    // Backpressure 1,0,0 pattern.
    rmode = 1'b1;
    start_burst(10'h020, 11'd16, 1);
    wait_done(300);
    check_burst(10'h020, 16);
    rmode = 1'b0;

    // Zero length.
    start_burst(10'h055, 11'd0, 1);
    wait_done(10);
    check("zero_done_cyc", done_cyc - start_cyc, 1);
    check("zero_reads", cs_addr_q.size(), 0);
    check("zero_valid", valid_cnt, 0);
    check("zero_busy", busy_cnt, 0);
    check("zero_done_cnt", done_cnt, 1);

    // Length clamp.
    start_burst(10'h000, 11'd2000, 1);
    wait_done(1300);
    check_burst(10'h000, 1024);

    // Reset mid-burst.
    start_burst(10'h040, 11'd10, 1);
    for (int i = 0; i < 50 && wd_q.size() < 3; i++) @(negedge clk);
    check("abort_reached_3", wd_q.size() >= 3, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    start_burst(10'h000, 11'd1, 1);
    wait_done(20);
    check_burst(10'h000, 1);

    // Start while busy is ignored.
    start_burst(10'h100, 11'd8, 1);
    repeat (2) @(negedge clk);
    start_burst(10'h200, 11'd3, 0);
    wait_done(60);
    check_burst(10'h100, 8);
    repeat (5) @(negedge clk);
    check("ignored_start_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qsys_system_onchip_mem_reader.md
QSYS_SYSTEM_ONCHIP_MEM_READER -- requirements
Module: qsys_system_onchip_mem_reader

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, output buffer depth in words; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; launches a read burst when idle.
REQ-005 base_address  input  10  first word address of the burst, sampled with start.
REQ-006 length  input  11  burst length in words, sampled with start.
REQ-007 busy  output  1  high from the cycle after an accepted start until done.
REQ-008 done  output  1  one-cycle pulse when the burst is complete.
REQ-009 address  output  10  word address to the on-chip memory.
REQ-010 byteenable  output  4  constant 4'b1111.
REQ-011 chipselect  output  1  read strobe to the memory.
REQ-012 write  output  1  constant 0.
REQ-013 writedata  output  32  constant 0.
REQ-014 clken  output  1  constant 1.
REQ-015 readdata  input  32  memory read data, valid exactly one cycle after chipselect.
REQ-016 out_data  output  32  stream data.
REQ-017 out_valid  output  1  stream valid.
REQ-018 out_ready  input  1  stream ready from the consumer.
REQ-019 out_sop  output  1  high with the first word of a burst.
REQ-020 out_eop  output  1  high with the last word of a burst.

Function
REQ-021 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-022 In IDLE, start=1 SHALL latch base_address and an effective length, then enter RUN; start in any other state SHALL be ignored.
REQ-023 The effective length SHALL be min(length, 1024); length=0 SHALL produce no reads and SHALL pulse done in the cycle after start, with busy remaining 0.
REQ-024 In RUN, a read (chipselect=1) SHALL be issued each cycle in which words remain to be issued and (fifo_count + reads_in_flight) < FIFO_DEPTH.
REQ-025 The read address SHALL increment by 1 per issued read and wrap from 1023 to 0.
REQ-026 Data returned on readdata SHALL be written into the FIFO at the end of the cycle following its chipselect; the FIFO SHALL never overflow.
REQ-027 The state SHALL move RUN->DRAIN in the cycle after the last read is issued, and DRAIN->IDLE when the eop word is accepted (out_valid & out_ready & out_eop).
REQ-028 done SHALL pulse in the same cycle as the eop handshake; busy SHALL be low from the next cycle.
REQ-029 out_valid SHALL equal "FIFO not empty"; out_data, out_sop and out_eop SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 out_sop SHALL mark word 0 and out_eop SHALL mark word N-1; for N=1 both SHALL be high on the same word.
REQ-031 The first chipselect SHALL occur in the cycle after start; with out_ready held at 1, the first out_valid SHALL occur 2 cycles after the first chipselect, and throughput SHALL be 1 word per cycle.
REQ-032 A FIFO push and pop in the same cycle SHALL leave fifo_count unchanged.
REQ-033 When no read is issued, address SHALL hold its last value and chipselect SHALL be 0.

Reset
REQ-034 On reset the block SHALL enter IDLE and flush the FIFO and in-flight tracking; busy, done, chipselect, out_valid, out_sop and out_eop SHALL be 0, and address and out_data SHALL be 0.
REQ-035 Reset asserted mid-burst SHALL abort the burst without a done pulse; the next start after reset deasserts SHALL operate normally.

Verification
REQ-036 Memory preloaded with word i = i; start, base=0x010, length=4, out_ready=1 -> data 0x10..0x13, sop on 0x10, eop on 0x13, done on the eop cycle.
REQ-037 base=0x3FE, length=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001 in order; data matches.
REQ-038 length=16 with out_ready toggling 1,0,0,1,... -> no word lost or duplicated, no more than FIFO_DEPTH reads outstanding, out_data stable while stalled.
REQ-039 length=0 -> done pulses the next cycle, with no chipselect, no out_valid and busy always 0; length=2000 -> exactly 1024 words.
REQ-040 Reset for 1 cycle after the 3rd word of a 10-word burst -> all outputs 0 the next cycle, no done; a new start with base=0, length=1 -> a single word with sop=eop=1.
REQ-041 start pulsed again while busy -> ignored; the burst completes unchanged.
